// File: rtl/dispatch_stage.sv
// dispatch_stage: single-entry dispatch buffer between decode and issue.
// Takes one decoded instruction per cycle, renames it (ROB slot and rd
// mapping) and resolves operands from the register file, the ROB or
// the CDB. It holds the instruction until the reservation station (RS)
// or the load/store queue (LSQ) takes it. Pending operands keep
// snooping the CDB while held.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable), flush_in
//   dec_*      : decoder handshake and decoded fields
//   reg_*      : register-file lookup, results and rename write of rd
//   rob_*      : ROB allocation, status and operand lookup
//   cdb_*      : CDB_N broadcast channels, packed with channel 0 in the LSBs
//   rs_*/lsq_* : issue handshakes
//   vj/vk/qj/qk/rj/rk/type/imm/dest/pc_out : issue payload
module dispatch_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ROB_W  = 4,
    parameter int TYPE_W = 6,
    parameter int CDB_N  = 2,
    parameter int LS_LO  = 10,
    parameter int LS_HI  = 17
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      dec_valid_in,
    output logic                      dec_ready_out,
    input  logic [TYPE_W-1:0]         dec_type_in,
    input  logic [REG_W-1:0]          dec_rs1_in,
    input  logic [REG_W-1:0]          dec_rs2_in,
    input  logic [REG_W-1:0]          dec_rd_in,
    input  logic [DATA_W-1:0]         dec_imm_in,
    input  logic [DATA_W-1:0]         dec_pc_in,
    output logic [REG_W-1:0]          reg_rs1_out,
    output logic [REG_W-1:0]          reg_rs2_out,
    input  logic [DATA_W-1:0]         reg_rs1_data_in,
    input  logic                      reg_rs1_busy_in,
    input  logic [ROB_W-1:0]          reg_rs1_robnum_in,
    input  logic [DATA_W-1:0]         reg_rs2_data_in,
    input  logic                      reg_rs2_busy_in,
    input  logic [ROB_W-1:0]          reg_rs2_robnum_in,
    output logic                      reg_en_out,
    output logic [REG_W-1:0]          reg_rd_out,
    output logic [ROB_W-1:0]          reg_rd_robnum_out,
    input  logic                      rob_full_in,
    input  logic [ROB_W-1:0]          rob_idle_pos_in,
    output logic                      rob_en_out,
    output logic [TYPE_W-1:0]         rob_type_out,
    output logic [DATA_W-1:0]         rob_pc_out,
    output logic [REG_W-1:0]          rob_rd_out,
    output logic [ROB_W-1:0]          rob_rs1_out,
    output logic [ROB_W-1:0]          rob_rs2_out,
    input  logic                      rob_rs1_rdy_in,
    input  logic [DATA_W-1:0]         rob_rs1_data_in,
    input  logic                      rob_rs2_rdy_in,
    input  logic [DATA_W-1:0]         rob_rs2_data_in,
    input  logic [CDB_N-1:0]          cdb_valid_in,
    input  logic [CDB_N*ROB_W-1:0]    cdb_tag_in,
    input  logic [CDB_N*DATA_W-1:0]   cdb_data_in,
    output logic                      rs_valid_out,
    input  logic                      rs_ready_in,
    output logic                      lsq_valid_out,
    input  logic                      lsq_ready_in,
    output logic [DATA_W-1:0]         vj_out,
    output logic [DATA_W-1:0]         vk_out,
    output logic [ROB_W-1:0]          qj_out,
    output logic [ROB_W-1:0]          qk_out,
    output logic                      rj_out,
    output logic                      rk_out,
    output logic [TYPE_W-1:0]         type_out,
    output logic [DATA_W-1:0]         imm_out,
    output logic [ROB_W-1:0]          dest_out,
    output logic [DATA_W-1:0]         pc_out
);

    typedef enum logic [0:0] {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    // Operand: value, producer tag, pending flag. A pending operand has v = 0;
    // a resolved operand has q = 0.
    typedef struct packed {
        logic [DATA_W-1:0] v;
        logic [ROB_W-1:0]  q;
        logic              r;
    } opnd_t;

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } cdb_hit_t;

    localparam logic [TYPE_W-1:0] LS_LO_T = TYPE_W'(LS_LO);
    localparam logic [TYPE_W-1:0] LS_HI_T = TYPE_W'(LS_HI);

    // The CDB is searched from the highest channel down, so the lowest
    // matching channel is written last and wins.
    function automatic cdb_hit_t cdb_match(
        input logic [ROB_W-1:0]        tag,
        input logic [CDB_N-1:0]        vld,
        input logic [CDB_N*ROB_W-1:0]  tags,
        input logic [CDB_N*DATA_W-1:0] datas
    );
        cdb_hit_t res;
        logic     m;
        res = '0;
        for (int i = CDB_N - 1; i >= 0; i--) begin
            m        = vld[i] && (tags[i*ROB_W +: ROB_W] == tag);
            res.hit  = res.hit | m;
            res.data = m ? datas[i*DATA_W +: DATA_W] : res.data;
        end
        return res;
    endfunction

    // Resolves an operand at accept time. Register x0 is hard zero. After that
    // the sources are tried in order: register file, ROB, then a CDB hit on the
    // producer tag.
    function automatic opnd_t resolve(
        input logic [REG_W-1:0]  idx,
        input logic              busy,
        input logic [DATA_W-1:0] rf_data,
        input logic [ROB_W-1:0]  robnum,
        input logic              rob_rdy,
        input logic [DATA_W-1:0] rob_data,
        input cdb_hit_t          hit
    );
        opnd_t o;
        o = '0;
        if (idx == '0) begin
            o = '0;
        end else if (!busy) begin
            o.v = rf_data;
        end else if (rob_rdy) begin
            o.v = rob_data;
        end else if (hit.hit) begin
            o.v = hit.data;
        end else begin
            o.r = 1'b1;
            o.q = robnum;
        end
        return o;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [TYPE_W-1:0] type_r, type_nxt_s;
    logic [DATA_W-1:0] imm_r, imm_nxt_s;
    logic [DATA_W-1:0] pc_r, pc_nxt_s;
    logic [ROB_W-1:0]  dest_r, dest_nxt_s;
    opnd_t             opj_r, opj_nxt_s, opj_mrg_s;
    opnd_t             opk_r, opk_nxt_s, opk_mrg_s;
    cdb_hit_t          hit1_s, hit2_s, hitj_s, hitk_s;
    logic              is_ls_s, issue_vld_s, fire_s, accept_s;

    // Handshake, issue qualification and pass-through lookup/allocation ports.
    assign is_ls_s       = (type_r >= LS_LO_T) && (type_r <= LS_HI_T);
    assign issue_vld_s   = (state_r == ST_FULL) && rdy_in && !flush_in;
    assign fire_s        = issue_vld_s && (is_ls_s ? lsq_ready_in : rs_ready_in);
    assign dec_ready_out = rdy_in && !flush_in && !rob_full_in
                           && ((state_r == ST_EMPTY) || fire_s);
    assign accept_s      = dec_valid_in && dec_ready_out;

    assign rs_valid_out      = issue_vld_s && !is_ls_s;
    assign lsq_valid_out     = issue_vld_s && is_ls_s;
    assign rob_en_out        = accept_s;
    assign reg_en_out        = accept_s && (dec_rd_in != '0);
    assign reg_rs1_out       = dec_rs1_in;
    assign reg_rs2_out       = dec_rs2_in;
    assign rob_rs1_out       = reg_rs1_robnum_in;
    assign rob_rs2_out       = reg_rs2_robnum_in;
    assign reg_rd_out        = dec_rd_in;
    assign reg_rd_robnum_out = rob_idle_pos_in;
    assign rob_type_out      = dec_type_in;
    assign rob_pc_out        = dec_pc_in;
    assign rob_rd_out        = dec_rd_in;

    // Payload: held operands with a same-cycle CDB hit merged in.
    assign vj_out   = opj_mrg_s.v;
    assign qj_out   = opj_mrg_s.q;
    assign rj_out   = opj_mrg_s.r;
    assign vk_out   = opk_mrg_s.v;
    assign qk_out   = opk_mrg_s.q;
    assign rk_out   = opk_mrg_s.r;
    assign type_out = type_r;
    assign imm_out  = imm_r;
    assign dest_out = dest_r;
    assign pc_out   = pc_r;

    // CDB lookups for the incoming operands and for the held pending ones.
    always_comb begin
        hit1_s = cdb_match(reg_rs1_robnum_in, cdb_valid_in, cdb_tag_in, cdb_data_in);
        hit2_s = cdb_match(reg_rs2_robnum_in, cdb_valid_in, cdb_tag_in, cdb_data_in);
        hitj_s = cdb_match(opj_r.q, cdb_valid_in, cdb_tag_in, cdb_data_in);
        hitk_s = cdb_match(opk_r.q, cdb_valid_in, cdb_tag_in, cdb_data_in);
    end

    // Merge a current-cycle broadcast into pending held operands.
    always_comb begin
        opj_mrg_s = opj_r;
        opk_mrg_s = opk_r;
        if (opj_r.r && hitj_s.hit) begin
            opj_mrg_s = '{v: hitj_s.data, q: '0, r: 1'b0};
        end else begin
            opj_mrg_s = opj_r;
        end
        if (opk_r.r && hitk_s.hit) begin
            opk_mrg_s = '{v: hitk_s.data, q: '0, r: 1'b0};
        end else begin
            opk_mrg_s = opk_r;
        end
    end

    // Next state: flush wins, then accept (which also covers a same-cycle
    // fire), then fire alone empties the slot; otherwise keep snooping.
    always_comb begin
        state_nxt_s = state_r;
        type_nxt_s  = type_r;
        imm_nxt_s   = imm_r;
        pc_nxt_s    = pc_r;
        dest_nxt_s  = dest_r;
        opj_nxt_s   = opj_r;
        opk_nxt_s   = opk_r;
        if (flush_in || (fire_s && !accept_s)) begin
            state_nxt_s = ST_EMPTY;
            type_nxt_s  = '0;
            imm_nxt_s   = '0;
            pc_nxt_s    = '0;
            dest_nxt_s  = '0;
            opj_nxt_s   = '0;
            opk_nxt_s   = '0;
        end else if (accept_s) begin
            state_nxt_s = ST_FULL;
            type_nxt_s  = dec_type_in;
            imm_nxt_s   = dec_imm_in;
            pc_nxt_s    = dec_pc_in;
            dest_nxt_s  = rob_idle_pos_in;
            opj_nxt_s   = resolve(dec_rs1_in, reg_rs1_busy_in, reg_rs1_data_in,
                                  reg_rs1_robnum_in, rob_rs1_rdy_in, rob_rs1_data_in, hit1_s);
            opk_nxt_s   = resolve(dec_rs2_in, reg_rs2_busy_in, reg_rs2_data_in,
                                  reg_rs2_robnum_in, rob_rs2_rdy_in, rob_rs2_data_in, hit2_s);
        end else if ((state_r == ST_FULL) && rdy_in) begin
            opj_nxt_s = opj_mrg_s;
            opk_nxt_s = opk_mrg_s;
        end else begin
            opj_nxt_s = opj_r;
            opk_nxt_s = opk_r;
        end
    end

    // State and held-instruction registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= ST_EMPTY;
            type_r  <= '0;
            imm_r   <= '0;
            pc_r    <= '0;
            dest_r  <= '0;
            opj_r   <= '0;
            opk_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            type_r  <= type_nxt_s;
            imm_r   <= imm_nxt_s;
            pc_r    <= pc_nxt_s;
            dest_r  <= dest_nxt_s;
            opj_r   <= opj_nxt_s;
            opk_r   <= opk_nxt_s;
        end
    end

endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed scenarios plus randomized traffic for
// dispatch_stage. A behavioural slot model predicts every output.
module tb_dispatch_stage;

    localparam int DW = 32;
    localparam int CN = 2;

    logic            clk_in;
    logic            rst_in;
    logic            rdy_in, flush_in, dec_valid_in, dec_ready_out;
    logic [5:0]      dec_type_in;
    logic [4:0]      dec_rs1_in, dec_rs2_in, dec_rd_in;
    logic [31:0]     dec_imm_in, dec_pc_in;
    logic [4:0]      reg_rs1_out, reg_rs2_out;
    logic [31:0]     reg_rs1_data_in, reg_rs2_data_in;
    logic            reg_rs1_busy_in, reg_rs2_busy_in;
    logic [3:0]      reg_rs1_robnum_in, reg_rs2_robnum_in;
    logic            reg_en_out;
    logic [4:0]      reg_rd_out;
    logic [3:0]      reg_rd_robnum_out;
    logic            rob_full_in;
    logic [3:0]      rob_idle_pos_in;
    logic            rob_en_out;
    logic [5:0]      rob_type_out;
    logic [31:0]     rob_pc_out;
    logic [4:0]      rob_rd_out;
    logic [3:0]      rob_rs1_out, rob_rs2_out;
    logic            rob_rs1_rdy_in, rob_rs2_rdy_in;
    logic [31:0]     rob_rs1_data_in, rob_rs2_data_in;
    logic [CN-1:0]   cdb_valid_in;
    logic [CN*4-1:0] cdb_tag_in;
    logic [CN*DW-1:0] cdb_data_in;
    logic            rs_valid_out, rs_ready_in, lsq_valid_out, lsq_ready_in;
    logic [31:0]     vj_out, vk_out, imm_out, pc_out;
    logic [3:0]      qj_out, qk_out, dest_out;
    logic            rj_out, rk_out;
    logic [5:0]      type_out;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one slot, operands as value/tag/pending triples.
    logic        m_full;
    logic [5:0]  m_type;
    logic [31:0] m_imm, m_pc;
    logic [3:0]  m_dest;
    logic [31:0] m_v[2];
    logic [3:0]  m_q[2];
    logic        m_p[2];

    dispatch_stage dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
        .dec_type_in(dec_type_in), .dec_rs1_in(dec_rs1_in), .dec_rs2_in(dec_rs2_in),
        .dec_rd_in(dec_rd_in), .dec_imm_in(dec_imm_in), .dec_pc_in(dec_pc_in),
        .reg_rs1_out(reg_rs1_out), .reg_rs2_out(reg_rs2_out),
        .reg_rs1_data_in(reg_rs1_data_in), .reg_rs1_busy_in(reg_rs1_busy_in),
        .reg_rs1_robnum_in(reg_rs1_robnum_in), .reg_rs2_data_in(reg_rs2_data_in),
        .reg_rs2_busy_in(reg_rs2_busy_in), .reg_rs2_robnum_in(reg_rs2_robnum_in),
        .reg_en_out(reg_en_out), .reg_rd_out(reg_rd_out), .reg_rd_robnum_out(reg_rd_robnum_out),
        .rob_full_in(rob_full_in), .rob_idle_pos_in(rob_idle_pos_in),
        .rob_en_out(rob_en_out), .rob_type_out(rob_type_out), .rob_pc_out(rob_pc_out),
        .rob_rd_out(rob_rd_out), .rob_rs1_out(rob_rs1_out), .rob_rs2_out(rob_rs2_out),
        .rob_rs1_rdy_in(rob_rs1_rdy_in), .rob_rs1_data_in(rob_rs1_data_in),
        .rob_rs2_rdy_in(rob_rs2_rdy_in), .rob_rs2_data_in(rob_rs2_data_in),
        .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
        .rs_valid_out(rs_valid_out), .rs_ready_in(rs_ready_in),
        .lsq_valid_out(lsq_valid_out), .lsq_ready_in(lsq_ready_in),
        .vj_out(vj_out), .vk_out(vk_out), .qj_out(qj_out), .qk_out(qk_out),
        .rj_out(rj_out), .rk_out(rk_out), .type_out(type_out), .imm_out(imm_out),
        .dest_out(dest_out), .pc_out(pc_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // First valid CDB channel (scanning upward) carrying the given tag.
    function automatic void cdb_find(input logic [3:0] tag, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = 32'd0;
        for (int c = 0; c < CN; c++) begin
            if (!hit && cdb_valid_in[c] && (cdb_tag_in[c*4 +: 4] == tag)) begin
                hit = 1'b1;
                d   = cdb_data_in[c*DW +: DW];
            end
        end
    endfunction

    task automatic model_reset();
        m_full = 1'b0; m_type = 6'd0; m_imm = 32'd0; m_pc = 32'd0; m_dest = 4'd0;
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 32'd0; m_q[k] = 4'd0; m_p[k] = 1'b0;
        end
    endtask

    task automatic drive_idle();
        rdy_in = 1'b1; flush_in = 1'b0; dec_valid_in = 1'b0; dec_type_in = 6'd0;
        dec_rs1_in = 5'd0; dec_rs2_in = 5'd0; dec_rd_in = 5'd0; dec_imm_in = 32'd0; dec_pc_in = 32'd0;
        reg_rs1_data_in = 32'd0; reg_rs2_data_in = 32'd0; reg_rs1_busy_in = 1'b0; reg_rs2_busy_in = 1'b0;
        reg_rs1_robnum_in = 4'd0; reg_rs2_robnum_in = 4'd0; rob_full_in = 1'b0; rob_idle_pos_in = 4'd0;
        rob_rs1_rdy_in = 1'b0; rob_rs2_rdy_in = 1'b0; rob_rs1_data_in = 32'd0; rob_rs2_data_in = 32'd0;
        cdb_valid_in = '0; cdb_tag_in = '0; cdb_data_in = '0; rs_ready_in = 1'b0; lsq_ready_in = 1'b0;
    endtask

    // Compare all outputs with the model for the current input set, then
    // advance the model to what the next rising edge should produce.
    task automatic settle_check();
        logic        is_ls, vld, fire, exp_rdy, acc, h, bsy, rrdy;
        logic [31:0] d, rfd, robd;
        logic [31:0] ev[2];
        logic [3:0]  eq[2];
        logic        ep[2];
        logic [4:0]  idx;
        logic [3:0]  rn;
        #1;
        is_ls = (m_type >= 6'd10) && (m_type <= 6'd17);
        for (int k = 0; k < 2; k++) begin
            ev[k] = m_v[k]; eq[k] = m_q[k]; ep[k] = m_p[k];
            if (m_p[k]) begin
                cdb_find(m_q[k], h, d);
                if (h) begin ev[k] = d; eq[k] = 4'd0; ep[k] = 1'b0; end
            end
        end
        vld     = m_full && rdy_in && !flush_in;
        fire    = vld && (is_ls ? lsq_ready_in : rs_ready_in);
        exp_rdy = rdy_in && !flush_in && !rob_full_in && (!m_full || fire);
        acc     = dec_valid_in && exp_rdy;
        check_eq("dec_ready", dec_ready_out, exp_rdy);
        check_eq("rs_valid", rs_valid_out, vld && !is_ls);
        check_eq("lsq_valid", lsq_valid_out, vld && is_ls);
        check_eq("rob_en", rob_en_out, acc);
        check_eq("reg_en", reg_en_out, acc && (dec_rd_in != 5'd0));
        check_eq("rob_rs1", rob_rs1_out, reg_rs1_robnum_in);
        check_eq("reg_rs2", reg_rs2_out, dec_rs2_in);
        if (acc) check_eq("rd_robnum", reg_rd_robnum_out, rob_idle_pos_in);
        if (m_full) begin
            check_eq("vj", vj_out, ev[0]); check_eq("qj", qj_out, eq[0]); check_eq("rj", rj_out, ep[0]);
            check_eq("vk", vk_out, ev[1]); check_eq("qk", qk_out, eq[1]); check_eq("rk", rk_out, ep[1]);
            check_eq("type", type_out, m_type); check_eq("imm", imm_out, m_imm);
            check_eq("dest", dest_out, m_dest); check_eq("pc", pc_out, m_pc);
        end
        if (flush_in) begin
            model_reset();
        end else if (acc) begin
            m_full = 1'b1; m_type = dec_type_in; m_imm = dec_imm_in; m_pc = dec_pc_in;
            m_dest = rob_idle_pos_in;
            for (int k = 0; k < 2; k++) begin
                idx  = (k == 0) ? dec_rs1_in : dec_rs2_in;
                bsy  = (k == 0) ? reg_rs1_busy_in : reg_rs2_busy_in;
                rfd  = (k == 0) ? reg_rs1_data_in : reg_rs2_data_in;
                rn   = (k == 0) ? reg_rs1_robnum_in : reg_rs2_robnum_in;
                rrdy = (k == 0) ? rob_rs1_rdy_in : rob_rs2_rdy_in;
                robd = (k == 0) ? rob_rs1_data_in : rob_rs2_data_in;
                cdb_find(rn, h, d);
                m_v[k] = 32'd0; m_q[k] = 4'd0; m_p[k] = 1'b0;
                if (idx == 5'd0) m_v[k] = 32'd0;
                else if (!bsy) m_v[k] = rfd;
                else if (rrdy) m_v[k] = robd;
                else if (h) m_v[k] = d;
                else begin m_q[k] = rn; m_p[k] = 1'b1; end
            end
        end else if (fire) begin
            model_reset();
        end else if (m_full && rdy_in) begin
            for (int k = 0; k < 2; k++) begin
                m_v[k] = ev[k]; m_q[k] = eq[k]; m_p[k] = ep[k];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        int cnt_en, cnt_v;
        rst_in = 1'b0;
        drive_idle();
        model_reset();
        repeat (2) @(negedge clk_in);
        check_eq("rst_rs_valid", rs_valid_out, 1'b0);
        check_eq("rst_lsq_valid", lsq_valid_out, 1'b0);
        check_eq("rst_vj", vj_out, 32'd0);
        check_eq("rst_pc", pc_out, 32'd0);
        rst_in = 1'b1;

        // ADD: rs1 ready in the register file, rs2 = x0.
        dec_valid_in = 1'b1; dec_type_in = 6'd1; dec_rs1_in = 5'd3; reg_rs1_data_in = 32'h11;
        dec_rs2_in = 5'd0; dec_rd_in = 5'd4; rob_idle_pos_in = 4'd7; dec_pc_in = 32'h100; dec_imm_in = 32'd5;
        settle_check();
        check_eq("add_accept", rob_en_out, 1'b1);
        tick();
        dec_valid_in = 1'b0; rs_ready_in = 1'b1;
        settle_check();
        check_eq("add_rs_valid", rs_valid_out, 1'b1);
        check_eq("add_vj", vj_out, 32'h11);
        check_eq("add_dest", dest_out, 4'd7);
        tick();

        // LW waiting on ROB 5, resolved by CDB channel 1.
        drive_idle();
        dec_valid_in = 1'b1; dec_type_in = 6'd12; dec_rs1_in = 5'd2; reg_rs1_busy_in = 1'b1;
        reg_rs1_robnum_in = 4'd5; rob_idle_pos_in = 4'd3; dec_pc_in = 32'h200;
        settle_check();
        tick();
        drive_idle();
        settle_check();
        check_eq("lw_pending", rj_out, 1'b1);
        tick();
        cdb_valid_in = 2'b10; cdb_tag_in = {4'd5, 4'd0}; cdb_data_in = {32'hABCD, 32'h0};
        settle_check();
        check_eq("lw_lsq_valid", lsq_valid_out, 1'b1);
        check_eq("lw_vj_bypass", vj_out, 32'hABCD);
        check_eq("lw_rj_bypass", rj_out, 1'b0);
        tick();
        drive_idle(); lsq_ready_in = 1'b1;
        settle_check();
        check_eq("lw_fire", lsq_valid_out, 1'b1);
        tick();
        settle_check();
        check_eq("lw_once", lsq_valid_out, 1'b0);
        tick();

        // Four back-to-back instructions.
        drive_idle(); rs_ready_in = 1'b1; cnt_en = 0; cnt_v = 0;
        for (int i = 0; i < 4; i++) begin
            dec_valid_in = 1'b1; dec_type_in = 6'd2; dec_pc_in = 32'(i); dec_rs1_in = 5'(i + 1);
            reg_rs1_data_in = 32'(i * 3); rob_idle_pos_in = 4'(i);
            settle_check();
            cnt_en += int'(rob_en_out); cnt_v += int'(rs_valid_out);
            tick();
        end
        dec_valid_in = 1'b0;
        settle_check();
        cnt_v += int'(rs_valid_out);
        tick();
        check_eq("b2b_accepts", 64'(cnt_en), 64'd4);
        check_eq("b2b_issues", 64'(cnt_v), 64'd4);

        // Flush while full with a new instruction offered.
        drive_idle(); dec_valid_in = 1'b1; dec_type_in = 6'd3; dec_pc_in = 32'h300;
        settle_check();
        tick();
        flush_in = 1'b1;
        settle_check();
        check_eq("flush_no_accept", rob_en_out, 1'b0);
        check_eq("flush_rs_valid", rs_valid_out, 1'b0);
        tick();
        flush_in = 1'b0; dec_valid_in = 1'b0;
        settle_check();
        check_eq("flush_empty", rs_valid_out, 1'b0);
        tick();

        // Asynchronous reset mid-cycle while full.
        dec_valid_in = 1'b1; dec_type_in = 6'd3; dec_pc_in = 32'h55; dec_rs1_in = 5'd1;
        reg_rs1_data_in = 32'h77; rob_idle_pos_in = 4'd9;
        settle_check();
        tick();
        dec_valid_in = 1'b0;
        settle_check();
        #2 rst_in = 1'b0;
        #1;
        check_eq("arst_rs_valid", rs_valid_out, 1'b0);
        check_eq("arst_vj", vj_out, 32'd0);
        check_eq("arst_pc", pc_out, 32'd0);
        check_eq("arst_dest", dest_out, 4'd0);
        model_reset();
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        settle_check();
        check_eq("post_rst_pc", pc_out, 32'd0);
        check_eq("post_rst_type", type_out, 6'd0);
        tick();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            flush_in = ($urandom_range(0, 19) == 0);
            rob_full_in = ($urandom_range(0, 7) == 0);
            dec_valid_in = 1'($urandom);
            dec_type_in = 6'($urandom_range(0, 24));
            dec_rs1_in = 5'($urandom_range(0, 7)); dec_rs2_in = 5'($urandom_range(0, 7));
            dec_rd_in = 5'($urandom_range(0, 7));
            dec_imm_in = $urandom; dec_pc_in = $urandom;
            reg_rs1_busy_in = 1'($urandom); reg_rs2_busy_in = 1'($urandom);
            reg_rs1_data_in = $urandom; reg_rs2_data_in = $urandom;
            reg_rs1_robnum_in = 4'($urandom_range(0, 3)); reg_rs2_robnum_in = 4'($urandom_range(0, 3));
            rob_rs1_rdy_in = ($urandom_range(0, 3) == 0); rob_rs2_rdy_in = ($urandom_range(0, 3) == 0);
            rob_rs1_data_in = $urandom; rob_rs2_data_in = $urandom;
            rob_idle_pos_in = 4'($urandom);
            cdb_valid_in = 2'($urandom);
            cdb_tag_in = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            cdb_data_in = {$urandom, $urandom};
            rs_ready_in = 1'($urandom); lsq_ready_in = 1'($urandom);
            settle_check();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
